// File: rtl/cfg_i2c_sequencer.sv
// Configuration sequencer: streams a ROM image to a single I2C device as write
// transactions through a byte-level I2C master, with settle pause and NACK retry.
module cfg_i2c_sequencer #(
    parameter int         MEM_WIDTH    = 24,
    parameter int         DATA_WIDTH   = 8,
    parameter int         WORD_NUMBER  = 326,
    parameter logic [6:0] SLAVE_ADDR   = 7'b111_0100,
    parameter int         PAUSE_AFTER  = 3,
    parameter int         PAUSE_CYCLES = 37_500_000,
    parameter int         MAX_RETRY    = 3,
    localparam int        AW           = (WORD_NUMBER > 1) ? $clog2(WORD_NUMBER) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic [AW-1:0]         rom_addr_o,
    input  logic [MEM_WIDTH-1:0]  rom_data_i,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_first_o,
    output logic                  tx_last_o,
    input  logic                  xfer_done_i,
    input  logic                  nack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [AW:0]           word_cnt_o
);

    localparam int BYTES      = MEM_WIDTH / DATA_WIDTH;
    localparam int BC_W       = $clog2(BYTES + 1);
    localparam int PC_W       = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES + 1) : 1;
    localparam int RT_W       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int PAUSE_LAST = (PAUSE_CYCLES > 0) ? PAUSE_CYCLES - 1 : 0;

    // A disabled pause maps to a word count of 0, which a completed word never reaches.
    localparam bit          PAUSE_EN = (PAUSE_AFTER > 0) && (PAUSE_AFTER < WORD_NUMBER);
    localparam logic [AW:0] PAUSE_AT = PAUSE_EN ? (AW+1)'(PAUSE_AFTER) : '0;
    localparam logic [AW:0] LAST_IDX = (AW+1)'(WORD_NUMBER);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_PAUSE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERROR = 3'd7;

    logic [2:0]            r_state;
    logic [AW:0]           r_idx;
    logic [AW:0]           r_word_cnt;
    logic [RT_W-1:0]       r_retry;
    logic [BC_W-1:0]       r_byte_cnt;
    logic [PC_W-1:0]       r_pause_cnt;
    logic [MEM_WIDTH-1:0]  r_shift;
    logic                  r_tx_valid;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_first;
    logic                  r_tx_last;

    logic [AW:0]           w_word_cnt_nxt;
    logic [AW:0]           w_idx_nxt;

    assign w_word_cnt_nxt = r_word_cnt + (AW+1)'(1);
    assign w_idx_nxt      = (r_idx == LAST_IDX) ? r_idx : r_idx + (AW+1)'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_word_cnt  <= '0;
            r_retry     <= '0;
            r_byte_cnt  <= '0;
            r_pause_cnt <= '0;
            r_shift     <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_tx_first  <= 1'b0;
            r_tx_last   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_i) begin
                        r_state    <= S_FETCH;
                        r_idx      <= '0;
                        r_word_cnt <= '0;
                        r_retry    <= '0;
                    end
                end
                S_FETCH: r_state <= S_LOAD;
                S_LOAD: begin
                    r_shift    <= rom_data_i;
                    r_byte_cnt <= '0;
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= DATA_WIDTH'({SLAVE_ADDR, 1'b0});
                    r_tx_first <= 1'b1;
                    r_tx_last  <= 1'b0;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (tx_ready_i) begin
                        if (r_byte_cnt == BC_W'(BYTES)) begin
                            r_tx_valid <= 1'b0;
                            r_tx_first <= 1'b0;
                            r_tx_last  <= 1'b0;
                            r_state    <= S_WAIT;
                        end else begin
                            r_tx_data  <= r_shift[MEM_WIDTH-1 -: DATA_WIDTH];
                            r_shift    <= r_shift << DATA_WIDTH;
                            r_tx_first <= 1'b0;
                            r_tx_last  <= (r_byte_cnt == BC_W'(BYTES - 1));
                            r_byte_cnt <= r_byte_cnt + BC_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (xfer_done_i) begin
                        if (!nack_i) begin
                            r_word_cnt <= w_word_cnt_nxt;
                            r_idx      <= w_idx_nxt;
                            r_retry    <= '0;
                            if (w_word_cnt_nxt == PAUSE_AT) begin
                                r_pause_cnt <= '0;
                                r_state     <= S_PAUSE;
                            end else if (w_idx_nxt == LAST_IDX) begin
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_FETCH;
                            end
                        end else if (r_retry < RT_W'(MAX_RETRY)) begin
                            // Word register was consumed by shifting; reload it from the held ROM output.
                            r_retry <= r_retry + RT_W'(1);
                            r_state <= S_LOAD;
                        end else begin
                            r_state <= S_ERROR;
                        end
                    end
                end
                S_PAUSE: begin
                    if (r_pause_cnt == PC_W'(PAUSE_LAST)) begin
                        r_state <= (r_idx == LAST_IDX) ? S_DONE : S_FETCH;
                    end else begin
                        r_pause_cnt <= r_pause_cnt + PC_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ROM address follows idx directly so the ROM's one-cycle latency lands in LOAD.
    assign rom_addr_o = r_idx[AW-1:0];
    assign tx_valid_o = r_tx_valid;
    assign tx_data_o  = r_tx_data;
    assign tx_first_o = r_tx_first;
    assign tx_last_o  = r_tx_last;
    assign busy_o     = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
    assign done_o     = (r_state == S_DONE);
    assign error_o    = (r_state == S_ERROR);
    assign word_cnt_o = r_word_cnt;

endmodule

// File: tb/tb_cfg_i2c_sequencer.sv
// Directed bench for cfg_i2c_sequencer: registered ROM model plus a byte-level
// I2C master model with scripted NACKs and optional random backpressure.
module tb_cfg_i2c_sequencer;

    localparam int AW = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] rom_addr_o;
    logic [23:0]   rom_data_i = '0;
    logic          tx_valid_o;
    logic          tx_ready_i = 1'b0;
    logic [7:0]    tx_data_o;
    logic          tx_first_o;
    logic          tx_last_o;
    logic          xfer_done_i = 1'b0;
    logic          nack_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [AW:0]   word_cnt_o;

    cfg_i2c_sequencer #(
        .MEM_WIDTH   (24),
        .DATA_WIDTH  (8),
        .WORD_NUMBER (4),
        .PAUSE_AFTER (2),
        .PAUSE_CYCLES(10),
        .MAX_RETRY   (2)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_data_i),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .tx_data_o  (tx_data_o),
        .tx_first_o (tx_first_o),
        .tx_last_o  (tx_last_o),
        .xfer_done_i(xfer_done_i),
        .nack_i     (nack_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o),
        .word_cnt_o (word_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    logic [23:0] rom [4] = '{24'h0B2400, 24'h0B25C0, 24'h000101, 24'h0FFF5A};
    logic [7:0]  exp_bytes [4][3] = '{'{8'h0B, 8'h24, 8'h00}, '{8'h0B, 8'h25, 8'hC0},
                                      '{8'h00, 8'h01, 8'h01}, '{8'h0F, 8'hFF, 8'h5A}};

    always @(posedge clk_i) rom_data_i <= rom[rom_addr_o];

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Logs of the observed stream: {first,last,data} per handshake, plus event cycles.
    logic [9:0] got_q [$];
    logic [9:0] exp_q [$];
    int         hs_cyc [$];
    int         b0_cyc [$];
    int         done_cyc [$];
    int         start_cyc = 0;

    bit bp_mode   = 1'b0;
    int nack_word = -1;
    int nack_left = 0;
    int tb_word   = 0;

    // Master model: logs handshakes, answers each STOP three cycles later, checks stall hold.
    initial begin : master
        int         cnt_down = 0;
        bit         prev_stall = 1'b0;
        bit         prev_vf = 1'b0;
        logic [9:0] prev_byte = '0;
        bit         pend;
        forever begin
            @(negedge clk_i);
            if (rst_i) cnt_down = 0;
            if (prev_stall && !rst_i) begin
                check("hold_valid", {31'd0, tx_valid_o}, 32'd1);
                check("hold_byte", {22'd0, tx_first_o, tx_last_o, tx_data_o}, {22'd0, prev_byte});
            end
            if (tx_valid_o && tx_first_o && !prev_vf) b0_cyc.push_back(cyc);
            if (tx_valid_o && tx_ready_i) begin
                got_q.push_back({tx_first_o, tx_last_o, tx_data_o});
                hs_cyc.push_back(cyc);
                if (tx_last_o) cnt_down = 3;
            end
            if (xfer_done_i) done_cyc.push_back(cyc);
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_vf    = tx_valid_o && tx_first_o;
            prev_byte  = {tx_first_o, tx_last_o, tx_data_o};

            @(posedge clk_i);
            #1;
            xfer_done_i = 1'b0;
            nack_i      = 1'b0;
            if (cnt_down > 0) begin
                cnt_down--;
                if (cnt_down == 0) begin
                    pend = (tb_word == nack_word) && (nack_left > 0);
                    if (pend) nack_left--;
                    else tb_word++;
                    xfer_done_i = 1'b1;
                    nack_i      = pend;
                end
            end
            tx_ready_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : watchdog
        #200_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        got_q.delete();
        exp_q.delete();
        hs_cyc.delete();
        b0_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic push_word(input int w);
        exp_q.push_back({2'b10, 8'hE8});
        exp_q.push_back({2'b00, exp_bytes[w][0]});
        exp_q.push_back({2'b00, exp_bytes[w][1]});
        exp_q.push_back({2'b01, exp_bytes[w][2]});
    endtask

    task automatic push_all();
        for (int w = 0; w < 4; w++) push_word(w);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, {22'd0, got_q[i]}, {22'd0, exp_q[i]});
    endtask

    task automatic pulse_start();
        @(posedge clk_i);
        #1;
        start_i   = 1'b1;
        start_cyc = cyc;
        tb_word   = 0;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done_o || error_o) && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, {31'd0, done_o | error_o}, 32'd1);
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'd0, tx_valid_o}, 32'd0);
        check({tag, "_flags"}, {30'd0, tx_first_o, tx_last_o}, 32'd0);
        check({tag, "_data"}, {24'd0, tx_data_o}, 32'd0);
        check({tag, "_status"}, {29'd0, busy_o, done_o, error_o}, 32'd0);
        check({tag, "_wc"}, {29'd0, word_cnt_o}, 32'd0);
        check({tag, "_addr"}, {30'd0, rom_addr_o}, 32'd0);
    endtask

    task automatic check_complete(input string tag);
        check({tag, "_done"}, {31'd0, done_o}, 32'd1);
        check({tag, "_err"}, {31'd0, error_o}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_wc"}, {29'd0, word_cnt_o}, 32'd4);
    endtask

    initial begin : main
        int n;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_zero("rst_init");

        // Nominal run with timing of start, back-to-back bytes, word gap and pause.
        clear_logs();
        pulse_start();
        wait_end("nom_end");
        check_complete("nom");
        push_all();
        check_stream("nom_byte");
        check("start_latency", b0_cyc[0] - start_cyc, 32'd3);
        check("back_to_back", hs_cyc[3] - hs_cyc[0], 32'd3);
        check("word_gap", b0_cyc[1] - done_cyc[0], 32'd3);
        check("pause_idle", b0_cyc[2] - done_cyc[1] - 1, 32'd12);
        repeat (3) @(negedge clk_i);
        check("done_sticky", {31'd0, done_o}, 32'd1);

        // Backpressure, with a stray start while busy that must be ignored.
        clear_logs();
        bp_mode = 1'b1;
        pulse_start();
        repeat (4) @(posedge clk_i);
        #1;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_end("bp_end");
        bp_mode = 1'b0;
        check_complete("bp");
        push_all();
        check_stream("bp_byte");

        // Single NACK on word 1, retried.
        clear_logs();
        nack_word = 1;
        nack_left = 1;
        pulse_start();
        wait_end("retry_end");
        check_complete("retry");
        push_word(0); push_word(1); push_word(1); push_word(2); push_word(3);
        check_stream("retry_byte");
        check("retry_gap", b0_cyc[2] - done_cyc[1], 32'd2);

        // Word 2 NACKed on every attempt: error, then a clean restart.
        clear_logs();
        nack_word = 2;
        nack_left = 3;
        pulse_start();
        wait_end("err_end");
        check("err_flag", {31'd0, error_o}, 32'd1);
        check("err_done", {31'd0, done_o}, 32'd0);
        check("err_busy", {31'd0, busy_o}, 32'd0);
        check("err_wc", {29'd0, word_cnt_o}, 32'd2);
        push_word(0); push_word(1); push_word(2); push_word(2); push_word(2);
        check_stream("err_byte");
        repeat (4) @(negedge clk_i);
        check("err_sticky", {31'd0, error_o}, 32'd1);
        clear_logs();
        nack_word = -1;
        pulse_start();
        wait_end("restart_end");
        check_complete("restart");
        push_all();
        check_stream("restart_byte");

        // Reset in the middle of the pause.
        clear_logs();
        pulse_start();
        n = 0;
        while (done_cyc.size() < 2 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        repeat (4) @(negedge clk_i);
        check("in_pause_busy", {31'd0, busy_o}, 32'd1);
        check("in_pause_wc", {29'd0, word_cnt_o}, 32'd2);
        apply_reset();
        check_zero("rst_pause");
        clear_logs();
        pulse_start();
        wait_end("rp_end");
        check_complete("rp");
        push_all();
        check_stream("rp_byte");

        // Reset in the middle of sending word 1.
        clear_logs();
        pulse_start();
        n = 0;
        while (!(done_cyc.size() >= 1 && tx_valid_o && !tx_first_o) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("in_send_valid", {31'd0, tx_valid_o}, 32'd1);
        apply_reset();
        check_zero("rst_send");
        clear_logs();
        pulse_start();
        wait_end("rs_end");
        check_complete("rs");
        push_all();
        check_stream("rs_byte");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cfg_i2c_sequencer.md
# cfg_i2c_sequencer

Parametrised configuration sequencer that streams a ROM image of `WORD_NUMBER` words, each `MEM_WIDTH` bits wide, to an I2C device as write transactions through a byte-level I2C master. It sits between the configuration ROM and the I2C byte master in the clock-chip bring-up path. Over the fixed single-device loader it adds:

- a configurable mid-sequence settle pause;
- per-word NACK retry with a bounded count;
- restartable operation;
- status reporting.

## Interface
- `MEM_WIDTH`, 24: ROM word width. Must be a multiple of `DATA_WIDTH`.
- `DATA_WIDTH`, 8: I2C byte width.
- `WORD_NUMBER`, 326: number of ROM words to send. Must be ≥ 1.
- `SLAVE_ADDR`, 7'b111_0100: 7-bit device address. The R/W bit is appended as the LSB and is always 0 (write).
- `PAUSE_AFTER`, 3: the pause is inserted after this many words complete. 0 disables the pause. Values ≥ `WORD_NUMBER` also disable it.
- `PAUSE_CYCLES`, 37_500_000: pause length in clocks (300 ms at 125 MHz). Computed in integer clocks only.
- `MAX_RETRY`, 3: retries per word after a NACK. 0 means no retry.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. Synchronous, active-high.
- `start_i`, in, 1: start pulse. Accepted only in IDLE, DONE or ERROR.
- `rom_addr_o`, out, AW = max(1, $clog2(WORD_NUMBER)): ROM read address.
- `rom_data_i`, in, MEM_WIDTH: ROM data. Valid one cycle after `rom_addr_o` changes.
- `tx_valid_o`, out, 1: byte available to the I2C master.
- `tx_ready_i`, in, 1: master accepts the byte when `tx_valid_o && tx_ready_i`.
- `tx_data_o`, out, DATA_WIDTH: byte to transmit.
- `tx_first_o`, out, 1: marks the first byte of a transaction (master issues START).
- `tx_last_o`, out, 1: marks the last byte of a transaction (master issues STOP).
- `xfer_done_i`, in, 1: one-cycle pulse from the master after STOP.
- `nack_i`, in, 1: NACK flag for the finished transaction. Qualified by `xfer_done_i`.
- `busy_o`, out, 1: high in every state except IDLE, DONE and ERROR.
- `done_o`, out, 1: high in DONE.
- `error_o`, out, 1: high in ERROR.
- `word_cnt_o`, out, AW+1: number of words completed successfully.

## Operation
- BYTES = MEM_WIDTH/DATA_WIDTH. Each transaction is BYTES+1 bytes:
  - byte 0 is `{SLAVE_ADDR,1'b0}` with `tx_first_o`=1;
  - the ROM word follows MSB-first, `rom_data_i[MEM_WIDTH-1 -: DATA_WIDTH]` first;
  - the final byte carries `tx_last_o`=1.
- States and transitions:
  - IDLE –start_i→ FETCH.
  - FETCH drives `rom_addr_o`=idx and lasts 1 cycle, then → LOAD.
  - LOAD registers `rom_data_i` into a shift register and sets byte_cnt=0, then → SEND.
  - SEND holds `tx_valid_o`=1. On each handshake it advances byte_cnt and shifts the word register. After handshaking byte BYTES it goes → WAIT.
  - WAIT handles `xfer_done_i`:
    - `nack_i`=0: word_cnt++, idx++, retry=0. Next state is PAUSE if word_cnt (new) == `PAUSE_AFTER`; else DONE if idx == WORD_NUMBER; else FETCH.
    - `nack_i`=1 with retry < MAX_RETRY: retry++, → LOAD. The same word is re-sent; no refetch is needed, but the ROM address is held.
    - `nack_i`=1 with retry == MAX_RETRY: → ERROR. idx and word_cnt are frozen.
  - PAUSE counts PAUSE_CYCLES clocks, then → DONE if idx == WORD_NUMBER, else → FETCH.
  - DONE or ERROR –start_i→ FETCH, with idx, word_cnt and retry cleared in the same cycle.
- `start_i` is ignored in any busy state.
- `xfer_done_i` is ignored outside WAIT.
- `tx_data_o`, `tx_first_o` and `tx_last_o` are registered and stable while `tx_valid_o`=1 and `tx_ready_i`=0.
- Counters:
  - pause counter width is $clog2(PAUSE_CYCLES+1);
  - idx saturates at WORD_NUMBER;
  - no wrap-around is permitted.

## Timing
- Reset values: state IDLE, all outputs 0, all counters 0. This applies in any state, including mid-SEND and mid-PAUSE. `tx_valid_o` drops the cycle after `rst_i` is sampled.
- Start latency: `start_i` is sampled at edge N. Then FETCH is at N+1, LOAD at N+2, and `tx_valid_o`=1 with byte 0 at N+3.
- Back-to-back bytes: with `tx_ready_i` held at 1, one byte is sent per clock. Byte k+1 is presented the cycle after byte k's handshake.
- Word-to-word gap: the cycle after a successful `xfer_done_i` is FETCH, then LOAD, and byte 0 of the next word is presented 3 cycles after the done pulse.
- Retry: byte 0 is presented 2 cycles after the NACKed `xfer_done_i`.
- Pause: `tx_valid_o` stays 0 for exactly PAUSE_CYCLES cycles in PAUSE, plus the FETCH and LOAD cycles.
- `done_o` and `error_o` assert the cycle after the deciding `xfer_done_i` (or after the pause ends). They stay asserted until `start_i` or `rst_i`.

## Test plan
Test parameters: WORD_NUMBER=4, PAUSE_AFTER=2, PAUSE_CYCLES=10, MAX_RETRY=2, ROM = 0x0B2400, 0x0B25C0, 0x000101, 0x0FFF5A.

- **Nominal run:** ready always 1, no NACK. Bytes must be E8,0B,24,00 / E8,0B,25,C0 / E8,00,01,01 / E8,0F,FF,5A, with first/last flags on bytes 0 and 3 of each group. `done_o`=1 and `word_cnt_o`=4.
- **Pause:** measure from the 2nd `xfer_done_i` to the word-2 byte 0. `tx_valid_o` must stay 0 for exactly 12 cycles (10 pause + FETCH + LOAD).
- **Backpressure:** `tx_ready_i` toggles randomly. The byte stream must be identical to the nominal run, and the outputs must stay stable while stalled.
- **Retry:** NACK on word 1 once. Word 1 is re-sent with byte 0 appearing 2 cycles after the NACK, and the run completes with `word_cnt_o`=4.
- **Error:** NACK word 2 three times. `error_o`=1, `word_cnt_o`=2, `busy_o`=0. A later `start_i` restarts from word 0 with E8,0B,24,00.
- **Reset mid-PAUSE and mid-SEND:** `rst_i` for one cycle. All outputs are 0 on the next cycle, and `start_i` restarts cleanly from word 0.
